servo_cmd_scheduler: RTL

//  Sequences and shares the 8-bit servo command that feeds the servo PWM generator.
//  Two requesters submit commands: the autonomous line-follow logic and manual switch control.
//  The block arbitrates between them once per PWM frame, slew-limits the output, and forces

---
 rtl/servo_cmd_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/servo_cmd_scheduler.sv
// Per-frame arbiter between the line-follow and manual servo requesters,
// with slew limiting and a command watchdog that falls back to NEUTRAL.
module servo_cmd_scheduler #(
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned SLEW_STEP     = 4,
  parameter int unsigned WDT_PERIODS   = 8,
  parameter logic [7:0]  NEUTRAL       = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       auto_valid,
  input  logic [7:0] auto_cmd,
  output logic       auto_ready,
  input  logic       man_valid,
  input  logic [7:0] man_cmd,
  output logic       man_ready,
  output logic [7:0] servo_out,
  output logic       frame_tick,
  output logic [1:0] mode,
  output logic       fault
);

  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int WW = $clog2(WDT_PERIODS + 1);

  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [WW-1:0] WMAX = WW'(WDT_PERIODS);
  localparam logic [8:0]    STEP = 9'(SLEW_STEP);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_AUTO = 2'd1;
  localparam logic [1:0] M_MAN  = 2'd2;
  localparam logic [1:0] M_FS   = 2'd3;

  logic [CW-1:0] cnt;
  logic [WW-1:0] wdt, wdt_n, wdt_inc;
  logic [7:0]    target, tgt_n;
  logic [7:0]    auto_data, man_data;
  logic          auto_full, man_full;
  logic          auto_take, man_take;
  logic [1:0]    mode_n;
  logic [8:0]    s9, t9, diff, step;
  logic          up;
  logic [7:0]    srv_n;

  assign frame_tick = (cnt == LAST);
  assign auto_ready = enable & ~auto_full;
  assign man_ready  = enable & ~man_full;
  assign auto_take  = auto_valid & auto_ready;
  assign man_take   = man_valid & man_ready;
  assign fault      = (mode == M_FS);
  assign wdt_inc    = wdt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (frame_tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  always_comb begin
    tgt_n  = target;
    mode_n = mode;
    wdt_n  = wdt;
    if (!enable) begin
      tgt_n  = NEUTRAL;
      mode_n = M_IDLE;
      wdt_n  = '0;
    end else if (frame_tick) begin
      if (man_full) begin
        tgt_n  = man_data;
        mode_n = M_MAN;
        wdt_n  = '0;
      end else if (auto_full) begin
        tgt_n  = auto_data;
        mode_n = M_AUTO;
        wdt_n  = '0;
      end else if (wdt != WMAX) begin
        wdt_n = wdt_inc;
        if (wdt_inc == WMAX) begin
          tgt_n  = NEUTRAL;
          mode_n = M_FS;
        end
      end
    end
  end

  // Slew toward the target being applied this tick, in 9 bits so no wrap
  always_comb begin
    s9    = {1'b0, servo_out};
    t9    = {1'b0, tgt_n};
    up    = (t9 > s9);
    diff  = up ? (t9 - s9) : (s9 - t9);
    step  = (diff > STEP) ? STEP : diff;
    srv_n = up ? 8'(s9 + step) : 8'(s9 - step);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo_out <= NEUTRAL;
      target    <= NEUTRAL;
      mode      <= M_IDLE;
      wdt       <= '0;
    end else begin
      target <= tgt_n;
      mode   <= mode_n;
      wdt    <= wdt_n;
      if (frame_tick) servo_out <= srv_n;
    end
  end

  // A capture in the tick cycle survives the clear and waits for the next tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_full <= 1'b0;
      man_full  <= 1'b0;
      auto_data <= '0;
      man_data  <= '0;
    end else if (!enable) begin
      auto_full <= 1'b0;
      man_full  <= 1'b0;
    end else begin
      if (auto_take) begin
        auto_full <= 1'b1;
        auto_data <= auto_cmd;
      end else if (frame_tick) begin
        auto_full <= 1'b0;
      end
      if (man_take) begin
        man_full <= 1'b1;
        man_data <= man_cmd;
      end else if (frame_tick) begin
        man_full <= 1'b0;
      end
    end
  end

endmodule
